// File: rtl/generic_fifo_sc_ctrl.sv
// generic_fifo_sc_ctrl
// Single-clock FIFO controller for an external synchronous dual-port RAM
// with a registered (one-cycle latency) read port. It generates the RAM
// addresses and enables, tracks occupancy and presents a push/pop interface.
//
// Ports:
//   clk, rst_n (async, active-low), clr (sync clear)
//   push/din         user write request and data
//   pop/dout         user read request; dout is ram_do passed through
//   dout_valid       dout carries the word popped on the previous edge
//   full/empty/almost_full/almost_empty, count   occupancy (registered)
//   overflow/underflow   sticky error flags, cleared by clr or reset
//   ram_waddr/ram_we/ram_wce/ram_di      RAM write port
//   ram_raddr/ram_rce/ram_oe/ram_do      RAM read port
module generic_fifo_sc_ctrl #(
  parameter int aw     = 5,
  parameter int dw     = 16,
  parameter int AF_LVL = (1 << aw) - 2,
  parameter int AE_LVL = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          push,
  input  logic [dw-1:0] din,
  input  logic          pop,
  output logic [dw-1:0] dout,
  output logic          dout_valid,
  output logic          full,
  output logic          empty,
  output logic          almost_full,
  output logic          almost_empty,
  output logic [aw:0]   count,
  output logic          overflow,
  output logic          underflow,
  output logic [aw-1:0] ram_waddr,
  output logic          ram_we,
  output logic          ram_wce,
  output logic [dw-1:0] ram_di,
  output logic [aw-1:0] ram_raddr,
  output logic          ram_rce,
  output logic          ram_oe,
  input  logic [dw-1:0] ram_do
);

  localparam logic [aw:0]   DEPTH_C = {1'b1, {aw{1'b0}}};
  localparam logic [aw:0]   AF_C    = AF_LVL[aw:0];
  localparam logic [aw:0]   AE_C    = AE_LVL[aw:0];
  localparam logic [aw:0]   CNT_ONE = {{aw{1'b0}}, 1'b1};
  localparam logic [aw-1:0] PTR_ONE = {{(aw-1){1'b0}}, 1'b1};

  logic [aw-1:0] r_wptr;
  logic [aw-1:0] r_rptr;
  logic [aw:0]   r_count;
  logic          r_dout_valid;
  logic          r_overflow;
  logic          r_underflow;

  logic w_full;
  logic w_empty;
  logic w_push_ok;
  logic w_pop_ok;

  // Flags decode registered count only, so they never follow push/pop
  // combinationally. Rejecting push-when-full and pop-when-empty also
  // guarantees the RAM never sees a same-address read and write.
  assign w_full    = (r_count == DEPTH_C);
  assign w_empty   = (r_count == '0);
  assign w_push_ok = push & ~w_full  & ~clr;
  assign w_pop_ok  = pop  & ~w_empty & ~clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_count      <= '0;
      r_dout_valid <= 1'b0;
      r_overflow   <= 1'b0;
      r_underflow  <= 1'b0;
    end else if (clr) begin
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_count      <= '0;
      r_dout_valid <= 1'b0;
      r_overflow   <= 1'b0;
      r_underflow  <= 1'b0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + PTR_ONE;
      if (w_pop_ok)  r_rptr <= r_rptr + PTR_ONE;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
      r_dout_valid <= w_pop_ok;
      if (push && w_full)  r_overflow  <= 1'b1;
      if (pop  && w_empty) r_underflow <= 1'b1;
    end
  end

  assign dout         = ram_do;
  assign dout_valid   = r_dout_valid;
  assign full         = w_full;
  assign empty        = w_empty;
  assign almost_full  = (r_count >= AF_C);
  assign almost_empty = (r_count <= AE_C);
  assign count        = r_count;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

  assign ram_waddr = r_wptr;
  assign ram_we    = w_push_ok;
  assign ram_wce   = w_push_ok;
  assign ram_di    = din;
  assign ram_raddr = r_rptr;
  assign ram_rce   = w_pop_ok;
  assign ram_oe    = 1'b1;

endmodule
